serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer built around a single full_adder instance; processes one bit per clock, LSB first.
- Captures WIDTH-bit operands through a valid/ready input handshake and holds the carry between cycles in a flop.
- Presents the sum and flags through a valid/ready output handshake.
- Lets an arithmetic unit trade area for latency by time-multiplexing one 1-bit adder.

---
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder time-multiplexed over WIDTH cycles, LSB first.
// Operands enter through a valid/ready handshake; the result and flags leave through another.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    // Subtraction is A + ~B + 1: invert B and force the initial carry.
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub | c_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = {fa_s, res_sh_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = fa_co ^ carry_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors plus random ops, compared every
// cycle against an arithmetic model of the transaction timing and results.

module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result packed as {overflow, carry_out, sum}, from plain signed/unsigned arithmetic.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic ci, input logic s);
        logic [WIDTH:0] full;
        logic           co;
        logic           ov;
        if (s) begin
            full = {1'b0, x} - {1'b0, y};
            co   = (x >= y);
            ov   = (x[WIDTH-1] != y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            co   = full[WIDTH];
            ov   = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        end
        return {ov, co, full[WIDTH-1:0]};
    endfunction

    // Transaction model: accepted op is busy for WIDTH cycles, then held until out_ready.
    int                 m_left;
    logic               m_valid;
    logic [WIDTH+1:0]   m_pend;
    logic [WIDTH+1:0]   m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_pend  <= '0;
            m_res   <= '0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
        end else if (in_valid) begin
            m_pend <= ref_op(a, b, c_in, sub);
            m_left <= WIDTH;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !m_valid && m_left == 0);
            chk("busy", busy, m_left != 0);
            chk("out_valid", out_valid, m_valid);
            chk("sum", sum, m_res[WIDTH-1:0]);
            chk("carry_out", carry_out, m_res[WIDTH]);
            chk("overflow", overflow, m_res[WIDTH+1]);
        end
    end

    // Directed op with literal expectations; hold stalls out_ready while offering a new op.
    task automatic do_op(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input logic ts, input logic [WIDTH-1:0] es,
                         input logic eco, input logic eov, input int hold);
        int lat;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, WIDTH);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, carry_out, eco);
        chk({nm, "_ovf"}, overflow, eov);
        for (int i = 0; i < hold; i++) begin
            a = ~ta; b = ~tb; c_in = ~tc; in_valid = 1'b1;
            @(posedge clk); #1;
            chk({nm, "_stall_valid"}, out_valid, 1'b1);
            chk({nm, "_stall_ready"}, in_ready, 1'b0);
            chk({nm, "_stall_sum"}, sum, es);
            chk({nm, "_stall_cout"}, carry_out, eco);
            chk({nm, "_stall_ovf"}, overflow, eov);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_idle_after"}, in_ready, 1'b1);
        chk({nm, "_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int guard;
        int ops;
        logic [WIDTH+1:0] r;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", sum, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1'b1);

        // Pin the reference model against hand arithmetic.
        r = ref_op(8'h80, 8'h01, 1'b1, 1'b1);
        chk("model_sub", r, {1'b1, 1'b1, 8'h7F});
        r = ref_op(8'h7F, 8'h00, 1'b1, 1'b0);
        chk("model_add", r, {1'b1, 1'b0, 8'h80});

        do_op("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        do_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        do_op("add7f00", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        do_op("sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        do_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        do_op("bp", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 5);

        // Reset three cycles into RUN: outputs clear at once, no result appears.
        a = 8'h12; b = 8'h34; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 8'h00);
        chk("midrst_cout", carry_out, 1'b0);
        chk("midrst_ovf", overflow, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (WIDTH + 3) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", out_valid, 1'b0);
        end
        do_op("postrst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 0);

        // Random ops with random consumer stalls; the per-cycle compare does the checking.
        ops = 0;
        guard = 0;
        while (ops < 1000 && guard < 60000) begin
            @(posedge clk); #1;
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                c_in = 1'($urandom); sub = 1'($urandom);
            end
            if (in_ready && $urandom_range(0, 3) != 0) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                c_in = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
                ops++;
            end
        end
        chk("random_ops_done", ops, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (WIDTH + 4) @(posedge clk);
        #1 chk("final_idle", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
